apb_sample_capture: RTL

- APB completer that captures filter-chain output samples into an internal FIFO.
- Exposes the samples to the host through the existing APB bridge as a memory-mapped register set.
- Occupies one PSELx slot alongside the coefficient RAM and is the readback path for the samples that the loaded coefficients produce.
- Provides capture control, sticky status flags, FIFO level, and a level-threshold interrupt.

---
 rtl/apb_sample_capture.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/apb_sample_capture.sv
// APB completer that captures signed filter samples into a FIFO and exposes
// control, sticky status, level, head-of-FIFO data and a level-threshold irq.
module apb_sample_capture #(
   parameter int ADDR_WIDTH  = 7,
   parameter int PDATA_WIDTH = 32,
   parameter int DATA_WIDTH  = 16,
   parameter int DEPTH       = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   PSEL,
   input  logic                   PENABLE,
   input  logic                   PWRITE,
   input  logic [ADDR_WIDTH-1:0]  PADDR,
   input  logic [PDATA_WIDTH-1:0] PWDATA,
   output logic                   PREADY,
   output logic [PDATA_WIDTH-1:0] PRDATA,
   input  logic [DATA_WIDTH-1:0]  sample_in,
   input  logic                   sample_vld,
   output logic                   irq
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RESP = 1'b1;

   localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] A_DATA   = ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] A_THRESH = ADDR_WIDTH'(3);

   logic [0:0]             state_q, state_d;
   logic [PDATA_WIDTH-1:0] prdata_q, prdata_d;
   logic                   cap_en_q, cap_en_d;
   logic [7:0]             thresh_q, thresh_d;
   logic                   ovf_q, ovf_d;
   logic                   udf_q, udf_d;
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]          count_q, count_d;
   logic                   irq_q, irq_d;
   logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

   logic                   access, wr_acc, rd_acc;
   logic                   sel_ctrl, sel_status, sel_data, sel_thresh;
   logic                   empty, full;
   logic                   clr, push, pop, ovf_set, udf_set;
   logic [DATA_WIDTH-1:0]  head;
   logic [PDATA_WIDTH-1:0] status_word;
   logic [PDATA_WIDTH-1:0] rd_mux;
   logic                   unused_pwdata;

   assign unused_pwdata = ^PWDATA[PDATA_WIDTH-1:8];

   always_comb begin
      access     = (state_q == S_IDLE) & PSEL & PENABLE;
      wr_acc     = access & PWRITE;
      rd_acc     = access & ~PWRITE;
      sel_ctrl   = (PADDR == A_CTRL);
      sel_status = (PADDR == A_STATUS);
      sel_data   = (PADDR == A_DATA);
      sel_thresh = (PADDR == A_THRESH);

      empty   = (count_q == '0);
      full    = (count_q == CW'(DEPTH));
      clr     = wr_acc & sel_ctrl & PWDATA[1];
      pop     = rd_acc & sel_data & ~empty & ~clr;
      udf_set = rd_acc & sel_data & empty;
      // A pop frees the slot this same cycle, so a full FIFO can still accept.
      push    = sample_vld & cap_en_q & (~full | pop) & ~clr;
      ovf_set = sample_vld & cap_en_q & full & ~pop & ~clr;
      head    = mem_q[rd_ptr_q];

      status_word       = '0;
      status_word[0]    = empty;
      status_word[1]    = full;
      status_word[2]    = ovf_q;
      status_word[3]    = udf_q;
      status_word[15:8] = 8'(count_q);

      rd_mux = '0;
      if (sel_ctrl) begin
         rd_mux[0] = cap_en_q;
      end else if (sel_status) begin
         rd_mux = status_word;
      end else if (sel_data) begin
         if (!empty) rd_mux = PDATA_WIDTH'($signed(head));
      end else if (sel_thresh) begin
         rd_mux[7:0] = thresh_q;
      end
   end

   always_comb begin
      state_d  = state_q;
      prdata_d = prdata_q;
      cap_en_d = cap_en_q;
      thresh_d = thresh_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      case (state_q)
         S_IDLE:  if (access) state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (rd_acc) prdata_d = rd_mux;
      if (wr_acc && sel_ctrl) cap_en_d = PWDATA[0];
      if (wr_acc && sel_thresh) thresh_d = PWDATA[7:0];

      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
         if (push && !pop) count_d = count_q + CW'(1);
         else if (pop && !push) count_d = count_q - CW'(1);
      end

      // Set events win over a same-cycle write-1-to-clear.
      ovf_d = ovf_set | (ovf_q & ~(wr_acc & sel_status & PWDATA[2]));
      udf_d = udf_set | (udf_q & ~(wr_acc & sel_status & PWDATA[3]));

      irq_d = (thresh_q != 8'd0) && (32'(count_d) >= 32'(thresh_q));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         prdata_q <= '0;
         cap_en_q <= 1'b0;
         thresh_q <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         prdata_q <= prdata_d;
         cap_en_q <= cap_en_d;
         thresh_q <= thresh_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         irq_q    <= irq_d;
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= sample_in;
   end

   assign PREADY = (state_q == S_RESP);
   assign PRDATA = prdata_q;
   assign irq    = irq_q;

endmodule
